// File: rtl/vec_addr_gen.sv
// Vector address generator: walks n elements and issues read-A/read-B/write address triples over valid/ready.
// Optional VAG_STRIDE_EN adds an 8-bit element stride latched at start (default build uses stride 1).
module vec_addr_gen #(
  parameter int W      = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      i_in,
  input  logic [W-1:0]      j_in,
  input  logic [W-1:0]      n_in,
  input  logic [W-1:0]      wom_addr_in,
  input  logic              wr_mul_pos_in,
`ifdef VAG_STRIDE_EN
  input  logic [7:0]        stride_in,
`endif
  input  logic              req_ready,
  output logic              req_valid,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [W-1:0]      elem_idx,
  output logic              last,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   r_state;
  logic [W-1:0] r_i;
  logic [W-1:0] r_j;
  logic [W-1:0] r_n;
  logic [W-1:0] r_wom;
  logic         r_wr_mul_pos;
  logic [W-1:0] r_k;
`ifdef VAG_STRIDE_EN
  logic [7:0]   r_stride;
`endif

  logic         w_run;
  logic         w_last_k;
  logic [W-1:0] w_n_minus1;
  logic [W-1:0] w_offset;

  assign w_run      = (r_state == S_RUN);
  assign w_n_minus1 = r_n - W'(1);
  assign w_last_k   = (r_k == w_n_minus1);

`ifdef VAG_STRIDE_EN
  assign w_offset = r_k * {{(W-8){1'b0}}, r_stride};
`else
  assign w_offset = r_k;
`endif

  // Sums are formed at W bits and only the low ADDR_W bits leave the block, so addresses wrap.
  assign req_valid = w_run;
  assign rd_addr_a = w_run ? ADDR_W'(r_i + w_offset) : '0;
  assign rd_addr_b = w_run ? ADDR_W'(r_j + w_offset) : '0;
  assign wr_addr   = !w_run      ? '0 :
                     r_wr_mul_pos ? ADDR_W'(r_wom + w_offset) : ADDR_W'(r_wom);
  assign elem_idx  = w_run ? r_k : '0;
  assign last      = w_run && w_last_k;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_i          <= '0;
      r_j          <= '0;
      r_n          <= '0;
      r_wom        <= '0;
      r_wr_mul_pos <= 1'b0;
      r_k          <= '0;
`ifdef VAG_STRIDE_EN
      r_stride     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (n_in != '0) begin
              r_i          <= i_in;
              r_j          <= j_in;
              r_n          <= n_in;
              r_wom        <= wom_addr_in;
              r_wr_mul_pos <= wr_mul_pos_in;
              r_k          <= '0;
`ifdef VAG_STRIDE_EN
              r_stride     <= stride_in;
`endif
              r_state      <= S_RUN;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          // The request stays up until accepted; nothing moves without req_ready.
          if (req_ready) begin
            if (w_last_k) begin
              r_state <= S_DONE;
            end else begin
              r_k <= r_k + W'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_addr_gen.sv
// Self-checking bench for vec_addr_gen: a transaction-queue model checked every cycle plus directed literal checks.
// Define VAG_STRIDE_EN to also exercise the stride port.
module tb_vec_addr_gen;

  localparam int W  = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  iIn = '0;
  logic [W-1:0]  jIn = '0;
  logic [W-1:0]  nIn = '0;
  logic [W-1:0]  womIn = '0;
  logic          wrMulPos = 1'b0;
  logic          reqReady = 1'b0;
`ifdef VAG_STRIDE_EN
  logic [7:0]    strideIn = 8'd1;
`endif

  logic          req_valid;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  elem_idx;
  logic          last;
  logic          busy;
  logic          done;

  vec_addr_gen #(.W(W), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .i_in         (iIn),
    .j_in         (jIn),
    .n_in         (nIn),
    .wom_addr_in  (womIn),
    .wr_mul_pos_in(wrMulPos),
`ifdef VAG_STRIDE_EN
    .stride_in    (strideIn),
`endif
    .req_ready    (reqReady),
    .req_valid    (req_valid),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .wr_addr      (wr_addr),
    .elem_idx     (elem_idx),
    .last         (last),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] w;
    logic [W-1:0]  idx;
    logic          isLast;
  } expT;

  expT  expQ[$];
  logic expDone = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   xfers = 0;

  task automatic checkOutput(input string name, input logic [83:0] act, input logic [83:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  function automatic logic [83:0] dutVec();
    return {req_valid, rd_addr_a, rd_addr_b, wr_addr, elem_idx, last, busy, done};
  endfunction

  function automatic logic [83:0] expVec();
    if (expQ.size() > 0)
      return {1'b1, expQ[0].a, expQ[0].b, expQ[0].w, expQ[0].idx, expQ[0].isLast, 1'b1, 1'b0};
    return {82'd0, expDone, expDone};
  endfunction

  // A walk is just the list of triples it must emit, computed straight from base + k*stride.
  task automatic buildWalk();
    logic [W-1:0] stride;
    logic [W-1:0] off;
    expT e;
`ifdef VAG_STRIDE_EN
    stride = {24'd0, strideIn};
`else
    stride = 32'd1;
`endif
    for (int k = 0; k < int'(nIn); k++) begin
      off   = 32'(k) * stride;
      e.a   = AW'(iIn + off);
      e.b   = AW'(jIn + off);
      e.w   = wrMulPos ? AW'(womIn + off) : AW'(womIn);
      e.idx = 32'(k);
      e.isLast = (k == int'(nIn) - 1);
      expQ.push_back(e);
    end
    if (nIn == '0) expDone = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        expQ.delete();
        expDone = 1'b0;
      end else if (expQ.size() > 0) begin
        if (reqReady) begin
          expQ.delete(0);
          if (expQ.size() == 0) expDone = 1'b1;
        end
      end else if (expDone) begin
        expDone = 1'b0;
      end else if (start) begin
        buildWalk();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("cycle", dutVec(), expVec());
      if (req_valid && reqReady) xfers++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [W-1:0] i, input logic [W-1:0] j, input logic [W-1:0] n,
                               input logic [W-1:0] wom, input logic wmp, input logic rdy);
    iIn      = i;
    jIn      = j;
    nIn      = n;
    womIn    = wom;
    wrMulPos = wmp;
    reqReady = rdy;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic checkTriple(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] w, input logic l);
    checkOutput(name, 84'({req_valid, rd_addr_a, rd_addr_b, wr_addr, last}), 84'({1'b1, a, b, w, l}));
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    tick();
    checkOutput("resetIdle", dutVec(), 84'd0);

    // Basic walk with per-element write addresses.
    xfers = 0;
    applyStimulus(32'h10, 32'h20, 32'd3, 32'h40, 1'b1, 1'b1);
    checkTriple("basic0", 16'h10, 16'h20, 16'h40, 1'b0);
    tick();
    checkTriple("basic1", 16'h11, 16'h21, 16'h41, 1'b0);
    tick();
    checkTriple("basic2", 16'h12, 16'h22, 16'h42, 1'b1);
    checkOutput("basicIdx", 84'(elem_idx), 84'd2);
    tick();
    checkOutput("basicDone", 84'({busy, done, req_valid}), 84'(3'b110));
    tick();
    checkOutput("basicIdle", 84'({busy, done}), 84'd0);
    checkOutput("basicXfers", 84'(xfers), 84'd3);

    // Accumulate mode with backpressure on element 1 and an ignored mid-walk start.
    xfers = 0;
    applyStimulus(32'h10, 32'h20, 32'd3, 32'h40, 1'b0, 1'b1);
    checkTriple("acc0", 16'h10, 16'h20, 16'h40, 1'b0);
    tick();
    checkTriple("acc1", 16'h11, 16'h21, 16'h40, 1'b0);
    reqReady = 1'b0;
    iIn = 32'h99;
    nIn = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkTriple("stall1", 16'h11, 16'h21, 16'h40, 1'b0);
    tick();
    checkTriple("stall2", 16'h11, 16'h21, 16'h40, 1'b0);
    tick();
    checkTriple("stall3", 16'h11, 16'h21, 16'h40, 1'b0);
    reqReady = 1'b1;
    tick();
    checkTriple("acc2", 16'h12, 16'h22, 16'h40, 1'b1);
    tick();
    checkOutput("accDone", 84'({busy, done, req_valid}), 84'(3'b110));
    tick();
    checkOutput("accXfers", 84'(xfers), 84'd3);

    // n = 0: straight to the done pulse.
    applyStimulus(32'h0, 32'h0, 32'd0, 32'h0, 1'b1, 1'b1);
    checkOutput("n0Done", 84'({busy, done, req_valid}), 84'(3'b110));
    tick();
    checkOutput("n0Idle", 84'({busy, done, req_valid}), 84'd0);

    // n = 1, then a back-to-back walk that wraps operand A.
    applyStimulus(32'h5, 32'h6, 32'd1, 32'h7, 1'b1, 1'b1);
    checkTriple("n1", 16'h5, 16'h6, 16'h7, 1'b1);
    tick();
    checkOutput("n1Done", 84'(done), 84'd1);
    tick();
    applyStimulus(32'hFFFF, 32'h100, 32'd2, 32'h200, 1'b1, 1'b1);
    checkTriple("wrap0", 16'hFFFF, 16'h100, 16'h200, 1'b0);
    tick();
    checkTriple("wrap1", 16'h0000, 16'h101, 16'h201, 1'b1);
    tick();
    tick();

    // Abort after two transfers; reset clears outputs at once and no done follows.
    applyStimulus(32'h30, 32'h50, 32'd7, 32'h70, 1'b1, 1'b1);
    tick();
    tick();
    checkTriple("abortPre", 16'h32, 16'h52, 16'h72, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("abortZero", dutVec(), 84'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("abortIdle", dutVec(), 84'd0);
    applyStimulus(32'h30, 32'h50, 32'd2, 32'h70, 1'b1, 1'b1);
    checkTriple("restart0", 16'h30, 16'h50, 16'h70, 1'b0);
    checkOutput("restartIdx", 84'(elem_idx), 84'd0);
    tick();
    tick();
    tick();

`ifdef VAG_STRIDE_EN
    strideIn = 8'd4;
    applyStimulus(32'h0, 32'h10, 32'd3, 32'h20, 1'b1, 1'b1);
    checkTriple("stride0", 16'h0, 16'h10, 16'h20, 1'b0);
    tick();
    checkTriple("stride1", 16'h4, 16'h14, 16'h24, 1'b0);
    tick();
    checkTriple("stride2", 16'h8, 16'h18, 16'h28, 1'b1);
    tick();
    tick();
    strideIn = 8'd1;
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_addr_gen.md
Name: vec_addr_gen

Overview:
- Downstream of scalar_reg in the vector ASIP datapath.
- Latches the scalar loop registers i, j, n and wom_addr, plus the wr_mul_pos flag, on a start pulse.
- Walks n elements, issuing one read-A / read-B / write address triple per accepted cycle over a valid/ready handshake to the vector memory/ALU stage.
- Signals completion with a one-cycle done pulse.

Parameters:
- W, 32, width of scalar inputs and the element counter.
- ADDR_W, 16, width of emitted addresses. Addresses are base+offset truncated to ADDR_W, with modulo 2^ADDR_W wrap.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset; 0 forces reset immediately.
- start  in  1  begin a walk; sampled only in IDLE.
- i_in  in  W  base address of operand A.
- j_in  in  W  base address of operand B.
- n_in  in  W  element count.
- wom_addr_in  in  W  base write address.
- wr_mul_pos_in  in  1  1 = write address advances per element; 0 = all writes target wom_addr (accumulate mode).
- req_ready  in  1  consumer accepts the current request.
- req_valid  out  1  request triple valid.
- rd_addr_a  out  ADDR_W  operand A address.
- rd_addr_b  out  ADDR_W  operand B address.
- wr_addr  out  ADDR_W  result address.
- elem_idx  out  W  index k of the current request.
- last  out  1  current request is element n-1.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
Reset:
- All outputs 0, all latched bases 0, counter 0, state IDLE.
- Reset asserted mid-walk aborts the walk; no done pulse is produced.

States:
- IDLE
  - start=1 with n_in!=0: latch i/j/n/wom_addr/wr_mul_pos, k=0, go to RUN.
  - start=1 with n_in==0: go to DONE (no requests issued).
  - start=0: stay.
- RUN
  - req_valid=1.
  - rd_addr_a = i+k.
  - rd_addr_b = j+k.
  - wr_addr = wom_addr+k if wr_mul_pos=1, else wom_addr.
  - Transfer occurs when req_valid && req_ready.
  - On transfer with k==n-1: go to DONE; otherwise k<=k+1.
  - No transfer: all outputs held stable; the request is never withdrawn.
- DONE
  - done=1 and req_valid=0 for exactly one cycle, then go to IDLE.

Handshake and timing:
- start seen at edge t -> first req_valid at t+1.
- Throughput is one element per cycle while req_ready=1.
- last = req_valid && (k==n-1).
- elem_idx = k while in RUN.
- start while busy=1 is ignored; inputs are not re-latched.
- Inputs changing after start have no effect on an active walk.

Arithmetic:
- Sums computed at W bits, output truncated to low ADDR_W bits (wrap, no error).
- Counter compare uses the full W bits.

Boundaries:
- n=1: single request with last=1, then DONE.
- req_ready=0 for many cycles: requests stall indefinitely with outputs stable.
- Back-to-back walks: start asserted in the cycle after done is accepted (IDLE); the next req_valid follows one cycle later.

Optional Feature:
VAG_STRIDE_EN:
- Defined: adds port stride_in (in, 8, unsigned element stride), latched at start.
- Defined: offset = k*stride for all three addresses (wr_addr only when wr_mul_pos=1).
- Defined: stride 0 makes every address equal its base.
- Undefined: port absent, implicit stride 1, behaviour exactly as above.

Test Plan:
- Reset release, idle -> all outputs 0, busy=0.
- Basic walk: start with i=0x10, j=0x20, n=3, wom=0x40, wr_mul_pos=1, req_ready=1 -> triples (10,20,40), (11,21,41), (12,22,42) on consecutive cycles; last on the third; done pulse on the next cycle; then busy=0.
- Backpressure and accumulate mode: same inputs with wr_mul_pos=0, req_ready low for cycles 2-4 of element 1 -> triple (11,21,40) held stable until accepted; wr_addr stays 0x40 throughout; exactly 3 transfers.
- Edge cases:
  - n=0 -> no req_valid; done one cycle after start.
  - n=1 -> one request with last=1.
  - i=0xFFFF, ADDR_W=16 -> second rd_addr_a = 0x0000.
- Abort: rst=0 asserted after 2 transfers of n=7 -> outputs 0 immediately; no done. Restart after reset -> fresh walk from k=0.
- Ignored start and stride: start pulsed mid-walk -> ignored. With VAG_STRIDE_EN, stride_in=4, i=0, n=3 -> rd_addr_a 0, 4, 8.
